// File: rtl/core_wb_arbiter.sv
// -----------------------------------------------------------------------------
// core_wb_arbiter
//   Writeback arbiter and register scoreboard in front of core_regfile write
//   port 3. NREQ writeback sources (ALU, LSU, mul/div, ...) share a single
//   regfile write port. One write is accepted per cycle and presented on
//   registered outputs one cycle later. A busy mask records the destination
//   registers of issued long-latency ops so the issue stage can stall on them.
//
//   Build variants: defining CORE_WB_ARB_FIXED_PRIO_EN selects fixed priority,
//   where the lowest-index valid requester always wins and rr_ptr is tied to 0.
//   The default build uses round robin starting at rr_ptr.
//
// Parameters
//   NREQ         number of writeback requesters (2..8), index 0 wins ties
// Ports
//   clk          core clock
//   rst          synchronous active-high reset
//   i_stall      1 = grant nothing this cycle
//   i_req_valid  per-requester pending writeback
//   i_req_waddr  per-requester destination register, 5 bits each
//   i_req_wdata  per-requester write data, 32 bits each
//   o_req_ready  combinational one-hot (or zero) grant
//   i_iss_valid  long-latency op issued this cycle
//   i_iss_rd     destination register of that op
//   o_we         regfile write enable
//   o_waddr      regfile write address
//   o_wdata      regfile write data
//   o_busy       bit r set = write to xr outstanding (bit 0 always 0)
// -----------------------------------------------------------------------------
module core_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_stall,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*5-1:0]    i_req_waddr,
  input  logic [NREQ*32-1:0]   i_req_wdata,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic                 i_iss_valid,
  input  logic [4:0]           i_iss_rd,
  output logic                 o_we,
  output logic [4:0]           o_waddr,
  output logic [31:0]          o_wdata,
  output logic [31:0]          o_busy
);

  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8) begin : g_nreq_bad
    $error("core_wb_arbiter: NREQ must be in the range 2..8");
  end

  logic [PW-1:0]   rr_ptr;
  logic [PW:0]     cand_sum;
  logic [PW-1:0]   cand;
  logic            hit;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] grant;
  logic [4:0]      sel_waddr;
  logic [31:0]     sel_wdata;
  logic            wr;
  logic [31:0]     clear_mask;
  logic [31:0]     set_mask;
  logic [31:0]     busy_next;

  // Arbitration: walk requesters starting at rr_ptr (wrapping mod NREQ) and
  // take the first valid one. With rr_ptr tied to 0 this is fixed priority.
  always_comb begin
    cand_sum  = '0;
    cand      = '0;
    hit       = 1'b0;
    win_found = 1'b0;
    win_idx   = '0;
    grant     = '0;
    if (!i_stall) begin
      for (int j = 0; j < NREQ; j++) begin
        cand_sum  = {1'b0, rr_ptr} + (PW+1)'(j);
        cand_sum  = (cand_sum >= (PW+1)'(NREQ)) ? (cand_sum - (PW+1)'(NREQ)) : cand_sum;
        cand      = cand_sum[PW-1:0];
        hit       = ~win_found & i_req_valid[cand];
        win_idx   = hit ? cand : win_idx;
        win_found = win_found | hit;
      end
      grant[win_idx] = win_found;
    end else begin
      grant = '0;
    end
  end

  assign o_req_ready = grant;

  // Route the granted requester's address/data to the write stage.
  always_comb begin
    sel_waddr = 5'd0;
    sel_wdata = 32'd0;
    for (int j = 0; j < NREQ; j++) begin
      sel_waddr = grant[j] ? i_req_waddr[j*5 +: 5]   : sel_waddr;
      sel_wdata = grant[j] ? i_req_wdata[j*32 +: 32] : sel_wdata;
    end
  end

  // Writes to x0 are accepted but never reach the regfile or the scoreboard.
  assign wr = win_found & (sel_waddr != 5'd0);

  // Scoreboard update: the set is applied after the clear so a new producer
  // for the same register keeps it busy.
  always_comb begin
    clear_mask = wr ? (32'd1 << sel_waddr) : 32'd0;
    set_mask   = (i_iss_valid && (i_iss_rd != 5'd0)) ? (32'd1 << i_iss_rd) : 32'd0;
    busy_next  = ((o_busy & ~clear_mask) | set_mask) & 32'hFFFF_FFFE;
  end

  // Registered write port and busy mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_we    <= 1'b0;
      o_waddr <= 5'd0;
      o_wdata <= 32'd0;
      o_busy  <= 32'd0;
    end else begin
      o_we   <= wr;
      o_busy <= busy_next;
      if (wr) begin
        o_waddr <= sel_waddr;
        o_wdata <= sel_wdata;
      end
    end
  end

`ifdef CORE_WB_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  // Round-robin pointer: the requester after the last accepted one starts
  // the next search; it only moves on an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (win_found) begin
      rr_ptr <= (win_idx == PW'(NREQ-1)) ? '0 : (win_idx + PW'(1));
    end
  end
`endif

endmodule

// File: tb/tb_core_wb_arbiter.sv
module tb_core_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [2:0]  req_valid;
  logic [14:0] req_waddr;
  logic [95:0] req_wdata;
  logic [2:0]  req_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy;

  int vectors;
  int miscompares;

  core_wb_arbiter #(.NREQ(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_stall     (stall),
    .i_req_valid (req_valid),
    .i_req_waddr (req_waddr),
    .i_req_wdata (req_wdata),
    .o_req_ready (req_ready),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .o_we        (we),
    .o_waddr     (waddr),
    .o_wdata     (wdata),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[idx]        = v;
    req_waddr[idx*5 +: 5]   = a;
    req_wdata[idx*32 +: 32] = d;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    stall     = 1'b0;
    req_valid = 3'b000;
    iss_valid = 1'b0;
    iss_rd    = 5'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b expected 0", we); end
    vectors++; if (waddr !== 5'd0) begin miscompares++; $display("FAIL reset_waddr: got %0d expected 0", waddr); end
    vectors++; if (wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata: got %h expected 0", wdata); end
    vectors++; if (busy !== 32'd0) begin miscompares++; $display("FAIL reset_busy: got %h expected 0", busy); end
    #1;
    vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL single_ready: got %b expected 001", req_ready); end
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL single_we: got %b expected 1", we); end
    vectors++; if (waddr !== 5'd5) begin miscompares++; $display("FAIL single_waddr: got %0d expected 5", waddr); end
    vectors++; if (wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_wdata: got %h expected deadbeef", wdata); end
    tick();
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL single_we_drop: got %b expected 0", we); end
    vectors++; if (waddr !== 5'd5) begin miscompares++; $display("FAIL single_waddr_hold: got %0d expected 5", waddr); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_ready [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [4:0] exp_addr  [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h1000_0001);
    set_req(1, 1'b1, 5'd2, 32'h1000_0002);
    set_req(2, 1'b1, 5'd3, 32'h1000_0003);
    for (int k = 0; k < 6; k++) begin
      #1;
      vectors++; if (req_ready !== exp_ready[k]) begin miscompares++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, exp_ready[k]); end
      tick();
      vectors++; if (we !== 1'b1 || waddr !== exp_addr[k]) begin miscompares++; $display("FAIL rr_write[%0d]: got we=%b waddr=%0d expected we=1 waddr=%0d", k, we, waddr, exp_addr[k]); end
    end
    req_valid = 3'b000;
    vectors++; if (wdata !== 32'h1000_0003) begin miscompares++; $display("FAIL rr_wdata: got %h expected 10000003", wdata); end
    vectors++; if (busy !== 32'd0) begin miscompares++; $display("FAIL rr_busy: got %h expected 0", busy); end
  endtask

  task automatic test_zero_addr();
    // pointer is 0 after the round-robin run; only req1 is valid
    set_req(1, 1'b1, 5'd0, 32'h0000_1234);
    #1;
    vectors++; if (req_ready !== 3'b010) begin miscompares++; $display("FAIL zero_ready: got %b expected 010", req_ready); end
    tick();
    set_req(1, 1'b0, 5'd0, 32'd0);
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL zero_we: got %b expected 0", we); end
    vectors++; if (waddr !== 5'd3) begin miscompares++; $display("FAIL zero_waddr_hold: got %0d expected 3", waddr); end
    vectors++; if (wdata !== 32'h1000_0003) begin miscompares++; $display("FAIL zero_wdata_hold: got %h expected 10000003", wdata); end
    vectors++; if (busy !== 32'd0) begin miscompares++; $display("FAIL zero_busy: got %h expected 0", busy); end
  endtask

  task automatic test_scoreboard();
    // pointer is 2 after the x0 accept of req1
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    vectors++; if (busy !== 32'h0000_0080) begin miscompares++; $display("FAIL sb_set: got %h expected 00000080", busy); end
    set_req(0, 1'b1, 5'd7, 32'h0000_00A7);
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL sb_ready: got %b expected 001", req_ready); end
    tick();
    iss_valid = 1'b0;
    vectors++; if (busy !== 32'h0000_0080 || we !== 1'b1) begin miscompares++; $display("FAIL sb_set_wins: got busy=%h we=%b expected busy=00000080 we=1", busy, we); end
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    vectors++; if (busy !== 32'd0 || we !== 1'b1 || waddr !== 5'd7) begin miscompares++; $display("FAIL sb_clear: got busy=%h we=%b waddr=%0d expected busy=0 we=1 waddr=7", busy, we, waddr); end
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    vectors++; if (busy !== 32'h0000_0008) begin miscompares++; $display("FAIL sb_set3: got %h expected 00000008", busy); end
    iss_rd = 5'd4;
    set_req(1, 1'b1, 5'd3, 32'h0000_0033);
    tick();
    set_req(1, 1'b0, 5'd0, 32'd0);
    vectors++; if (busy !== 32'h0000_0010) begin miscompares++; $display("FAIL sb_set_clear_diff: got %h expected 00000010", busy); end
    iss_rd = 5'd0;
    tick();
    iss_valid = 1'b0;
    vectors++; if (busy !== 32'h0000_0010) begin miscompares++; $display("FAIL sb_x0_issue: got %h expected 00000010", busy); end
  endtask

  task automatic test_stall();
    do_reset();
    set_req(0, 1'b1, 5'd10, 32'h0000_000A);
    tick();
    // req0 accepted, pointer now 1
    set_req(0, 1'b1, 5'd10, 32'h0000_00AA);
    set_req(2, 1'b1, 5'd12, 32'h0000_00CC);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL stall_ready[%0d]: got %b expected 000", k, req_ready); end
      tick();
      vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL stall_we[%0d]: got %b expected 0", k, we); end
    end
    stall = 1'b0;
    #1;
    vectors++; if (req_ready !== 3'b100) begin miscompares++; $display("FAIL stall_release_ready: got %b expected 100", req_ready); end
    tick();
    set_req(2, 1'b0, 5'd0, 32'd0);
    vectors++; if (we !== 1'b1 || waddr !== 5'd12) begin miscompares++; $display("FAIL stall_first: got we=%b waddr=%0d expected we=1 waddr=12", we, waddr); end
    #1;
    vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL stall_second_ready: got %b expected 001", req_ready); end
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    vectors++; if (we !== 1'b1 || waddr !== 5'd10 || wdata !== 32'h0000_00AA) begin miscompares++; $display("FAIL stall_second: got we=%b waddr=%0d wdata=%h expected we=1 waddr=10 wdata=000000aa", we, waddr, wdata); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    iss_rd = 5'd7;
    set_req(0, 1'b1, 5'd9, 32'h0000_0099);
    tick();
    iss_valid = 1'b0;
    vectors++; if (busy !== 32'h0000_0090 || we !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got busy=%h we=%b expected busy=00000090 we=1", busy, we); end
    // pointer is 1 here; after reset req0 must win over req2
    set_req(0, 1'b1, 5'd6, 32'h0000_0066);
    set_req(2, 1'b1, 5'd8, 32'h0000_0088);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (we !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin miscompares++; $display("FAIL mid_regs: got we=%b waddr=%0d wdata=%h expected 0/0/0", we, waddr, wdata); end
    vectors++; if (busy !== 32'd0) begin miscompares++; $display("FAIL mid_busy: got %h expected 0", busy); end
    #1;
    vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL mid_ready: got %b expected 001", req_ready); end
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    set_req(2, 1'b0, 5'd0, 32'd0);
    vectors++; if (we !== 1'b1 || waddr !== 5'd6 || wdata !== 32'h0000_0066) begin miscompares++; $display("FAIL mid_grant: got we=%b waddr=%0d wdata=%h expected we=1 waddr=6 wdata=00000066", we, waddr, wdata); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    req_valid   = 3'b000;
    req_waddr   = '0;
    req_wdata   = '0;
    iss_valid   = 1'b0;
    iss_rd      = 5'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_addr();
    test_scoreboard();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
